// File: rtl/hamming_uart_tx_fifo.sv
// Hamming(7,4) encoder feeding a codeword FIFO, drained back to back by a UART
// serialiser with configurable divider, optional even parity and 1/2 stop bits.
module hamming_uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [3:0]                   in_data,
  output logic                         in_ready,
  input  logic                         clr_ovf,
  output logic                         tx,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_L   = (PW+1)'(FIFO_DEPTH);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  logic [6:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, empty;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg;
  logic          tx_q, tx_n, load, bit_end;

  assign empty      = (count == '0);
  assign in_ready   = (count != DEPTH_L);
  assign push       = in_valid && in_ready;
  assign fifo_count = count;
  assign tx         = tx_q;
  assign tx_busy    = (state != IDLE);

  // Encode on entry; storage is data-only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hamming_encode(in_data);
    if (load) shreg <= {1'b0, mem[rd_ptr]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      // A rejected push wins over a same-cycle clear.
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (clr_ovf)          overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      tx_q    <= tx_n;
    end
  end

  // tx_n is the line level for the cycle after the edge, so tx stays registered.
  always_comb begin
    state_n = state;
    baud_n  = baud + BW'(1);
    bit_n   = bit_cnt;
    tx_n    = tx_q;
    pop     = 1'b0;
    load    = 1'b0;
    bit_end = (baud == BAUD_LAST);
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = ^shreg;
            end else begin
              state_n = STOP;
              bit_n   = '0;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 3'd1;
            tx_n  = shreg[bit_n];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == STOP_LAST) begin
            // Chain straight into the next frame when more data is queued.
            if (!empty) begin
              pop     = 1'b1;
              load    = 1'b1;
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/hamming_uart_tx_fifo.md
# hamming_uart_tx_fifo

Parametrised successor to the fixed Hamming(7,4)-plus-UART transmit path. The block accepts 4-bit nibbles through a valid/ready handshake, Hamming(7,4)-encodes them on entry, and buffers the codewords in a FIFO. A UART serialiser with a configurable baud divider, optional even parity and 1 or 2 stop bits drains the FIFO back to back. It sits between the tile input pins and the TX pad, and replaces free-running per-nibble transmission with buffered, flow-controlled transmission.

## Interface

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; legal range ≥ 2.
- FIFO_DEPTH, 4: number of codeword entries; power of two, ≥ 2.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  nibble offered.
- in_data  input  4  nibble; bit 0 is d0.
- in_ready  output  1  equals !full; acceptance occurs when in_valid && in_ready at a rising edge.
- clr_ovf  input  1  synchronous clear of overflow.
- tx  output  1  UART line; idles high; registered.
- tx_busy  output  1  high whenever the serialiser state is not IDLE.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set when in_valid && !in_ready.

## Operation

- Encoding is applied at write time; the FIFO stores 7-bit codewords.
  - p1 = d0^d1^d3, p2 = d0^d2^d3, p3 = d1^d2^d3.
  - Codeword bits [0..6] = p1, p2, d0, p3, d1, d2, d3.
- Transmitted byte = {1'b0, code[6:0]}, sent LSB first.
- Frame order: start bit (0), 8 data bits, parity (if PARITY_EN; XOR of the 8 data bits), STOP_BITS stop bits (1).
- FIFO is circular, with read/write pointers that wrap at FIFO_DEPTH.
  - Push and pop in the same cycle: count is unchanged.
  - Push while full never occurs, because in_ready is low.
- Serialiser FSM states and transitions:
  - IDLE → START when the FIFO is not empty; the pop and the shift-register load happen on that edge.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA runs 8 bits, using a bit counter of 0..7.
  - DATA → PARITY if PARITY_EN, else → STOP.
  - PARITY → STOP.
  - STOP lasts STOP_BITS × CLKS_PER_BIT cycles.
  - On the final STOP cycle: if the FIFO is not empty, pop and go directly to START (zero idle cycles between frames); otherwise go to IDLE.
- The baud counter runs from 0 to CLKS_PER_BIT-1 and resets on every state or bit advance.
- overflow: set has priority over clr_ovf when both occur in the same cycle; cleared otherwise by clr_ovf or rst.
- Reset (including mid-frame): tx=1, tx_busy=0, fifo_count=0, overflow=0, in_ready=1, FSM=IDLE. FIFO contents are discarded and the partial frame is abandoned.

## Timing

- Acceptance at edge k: fifo_count increments at edge k.
- At edge k+1 (serialiser idle): the FIFO pops, tx falls to 0, and tx_busy rises. Latency from acceptance to start bit is 1 cycle.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- Frame length is (9 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- tx_busy falls on the edge after the last stop-bit cycle, and only if the FIFO is empty.
- in_ready is combinational from the occupancy register; it is not combinationally dependent on in_valid.
- Pushing into a full FIFO in the same cycle as a pop is not accepted, because in_ready is based on full only. The nibble is dropped and overflow sets.

## Test plan

- Frame encoding: CLKS_PER_BIT=4, PARITY_EN=0. Push 0xB.
  - Required: tx bits = 0, 1,0,1,0,1,0,1,0, 1 (code 0x55); each bit held 4 cycles; tx_busy high for 40 cycles.
- Parity: PARITY_EN=1, STOP_BITS=2. Push 0xF then 0x0.
  - Required: frame 1 data = 0x7F with parity 1; frame 2 data = 0x00 with parity 0.
  - Required: each frame is 12 × CLKS_PER_BIT cycles, and the frames are back to back with no idle cycle.
- Fill and overflow: FIFO_DEPTH=4. Push 6 nibbles on consecutive cycles.
  - Required: first nibble popped after 1 cycle; fifo_count reaches 4 and in_ready=0; the 6th nibble is dropped and overflow=1.
  - Required: clr_ovf together with another rejected push keeps overflow=1.
- Simultaneous push and pop: issue a push on the final STOP cycle with 1 entry queued.
  - Required: fifo_count stays 1, and the next START begins on the following cycle.
- Reset mid-frame: assert rst during DATA bit 3.
  - Required: tx=1 and tx_busy=0 immediately, without waiting for a clock; fifo_count=0.
  - Required: after release, a new push transmits correctly.
- Divider edge: CLKS_PER_BIT=2. Stream 0x0..0xF.
  - Required: all 16 codewords are received correctly by a bench UART model with a Hamming decoder; no gaps between frames.
